// File: rtl/button_mode_select.sv
// -----------------------------------------------------------------------------
// button_mode_select
//
// Classifies a debounced push-button level into short and long press events.
// It also maintains the effect-selection state for the VFX mode multiplexer:
//   - a short press advances `mode` (wrapping), or leaves bypass if it is set;
//   - a long press toggles `bypass`.
//
// The input must already be synchronised and debounced; no filtering is done
// here. Every output is registered, so there is no combinational path from
// `btn_level` to any output.
//
// Parameters:
//   NUM_MODES   - number of effect modes (>= 2); mode runs 0..NUM_MODES-1
//   LONG_COUNTS - hold time in clk cycles that classifies a long press (>= 2)
//   ACTIVE_LOW  - 1: btn_level == 0 means pressed
//
// Ports:
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   btn_level    in   debounced button level, synchronous to clk
//   mode         out  current effect index
//   bypass       out  1 = effects bypassed
//   short_pulse  out  one-cycle strobe on a classified short press
//   long_pulse   out  one-cycle strobe on a classified long press
//   mode_changed out  one-cycle strobe whenever mode or bypass changes
// -----------------------------------------------------------------------------
module button_mode_select #(
  parameter int unsigned NUM_MODES   = 4,
  parameter int unsigned LONG_COUNTS = 50_000_000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         btn_level,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic                         bypass,
  output logic                         short_pulse,
  output logic                         long_pulse,
  output logic                         mode_changed
);

  localparam int unsigned ModeW = $clog2(NUM_MODES);
  localparam int unsigned CntW  = $clog2(LONG_COUNTS);

  localparam logic [ModeW-1:0] LastMode = ModeW'(NUM_MODES - 1);
  localparam logic [CntW-1:0]  LastCnt  = CntW'(LONG_COUNTS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLong
  } state_e;

  state_e          state;
  logic [CntW-1:0] hold_cnt;
  logic            prev_pressed;
  logic            pressed;
  logic            press_edge;

  // Normalise polarity so the rest of the logic only thinks in "pressed".
  assign pressed    = ACTIVE_LOW ? ~btn_level : btn_level;
  assign press_edge = pressed & ~prev_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      hold_cnt     <= '0;
      // Reset as "pressed": a button held through reset must be released
      // before it can generate an event.
      prev_pressed <= 1'b1;
      mode         <= '0;
      bypass       <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      mode_changed <= 1'b0;
    end else begin
      prev_pressed <= pressed;

      // Strobes default low so each one lasts exactly one cycle.
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      mode_changed <= 1'b0;

      unique case (state)
        StIdle: begin
          if (press_edge) begin
            state    <= StPressed;
            hold_cnt <= '0;
          end
        end

        StPressed: begin
          if (!pressed) begin
            // Release wins over the long threshold on the same edge.
            state        <= StIdle;
            short_pulse  <= 1'b1;
            mode_changed <= 1'b1;
            if (bypass) begin
              bypass <= 1'b0;
            end else if (mode == LastMode) begin
              mode <= '0;
            end else begin
              mode <= mode + 1'b1;
            end
          end else if (hold_cnt == LastCnt) begin
            state        <= StLong;
            long_pulse   <= 1'b1;
            mode_changed <= 1'b1;
            bypass       <= ~bypass;
          end else begin
            // Cannot wrap: the branch above leaves this state at LastCnt.
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        StLong: begin
          // Counter stays frozen; the release itself is silent.
          if (!pressed) begin
            state <= StIdle;
          end
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_mode_select.sv
module tb_button_mode_select;

  localparam int unsigned NM = 3;
  localparam int unsigned LC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_level = 1'b1;
  logic [1:0] mode;
  logic       bypass;
  logic       short_pulse;
  logic       long_pulse;
  logic       mode_changed;

  button_mode_select #(
    .NUM_MODES  (NM),
    .LONG_COUNTS(LC),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_level   (btn_level),
    .mode        (mode),
    .bypass      (bypass),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: tracks how many consecutive edges a press has been
  // sampled, and derives events from the press duration.
  bit m_prev;
  int m_len;     // 0 = no press in progress, else samples since press edge
  bit m_long;    // press already classified long, waiting for release
  int m_mode;
  bit m_bypass;
  bit e_short;
  bit e_long;
  bit e_chg;

  int wrap_exp[4] = '{1, 2, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mode", {30'd0, mode}, m_mode);
    chk("bypass", {31'd0, bypass}, {31'd0, m_bypass});
    chk("short_pulse", {31'd0, short_pulse}, {31'd0, e_short});
    chk("long_pulse", {31'd0, long_pulse}, {31'd0, e_long});
    chk("mode_changed", {31'd0, mode_changed}, {31'd0, e_chg});
  endtask

  task automatic model_reset();
    m_prev   = 1'b1;
    m_len    = 0;
    m_long   = 1'b0;
    m_mode   = 0;
    m_bypass = 1'b0;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_chg    = 1'b0;
  endtask

  task automatic model_edge(input bit p);
    e_short = 1'b0;
    e_long  = 1'b0;
    e_chg   = 1'b0;
    if (m_long) begin
      if (!p) m_long = 1'b0;
    end else if (m_len > 0) begin
      if (!p) begin
        m_len   = 0;
        e_short = 1'b1;
        e_chg   = 1'b1;
        if (m_bypass) m_bypass = 1'b0;
        else m_mode = (m_mode + 1) % NM;
      end else begin
        m_len++;
        // Long once pressed was seen on LC+1 consecutive edges.
        if (m_len == LC + 1) begin
          m_len    = 0;
          m_long   = 1'b1;
          e_long   = 1'b1;
          e_chg    = 1'b1;
          m_bypass = !m_bypass;
        end
      end
    end else if (p && !m_prev) begin
      m_len = 1;
    end
    m_prev = p;
  endtask

  // Called at posedge+1; drives the level, samples the next edge, checks.
  task automatic step(input logic lvl);
    btn_level = lvl;
    @(posedge clk);
    #1;
    model_edge(!lvl);
    check_all();
  endtask

  task automatic press(input int n, input int gap);
    repeat (n) step(1'b0);
    repeat (gap) step(1'b1);
  endtask

  // Called at posedge+1; asserts reset between edges and checks the
  // asynchronous clear before any clock edge occurs.
  task automatic async_reset(input logic lvl_after);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    btn_level = lvl_after;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();

    // Reset
    @(posedge clk);
    #1;
    async_reset(1'b1);
    repeat (3) step(1'b1);
    chk("reset_mode", {30'd0, mode}, 0);

    // Short-press wrap
    for (int i = 0; i < 4; i++) begin
      repeat (3) step(1'b0);
      step(1'b1);
      chk("wrap_short", {31'd0, short_pulse}, 1);
      chk("wrap_mode", {30'd0, mode}, wrap_exp[i]);
      step(1'b1);
      chk("wrap_short_end", {31'd0, short_pulse}, 0);
    end

    // Release sampled exactly at k+LC: short press
    repeat (LC) step(1'b0);
    step(1'b1);
    chk("thr_short", {31'd0, short_pulse}, 1);
    chk("thr_mode", {30'd0, mode}, 2);
    chk("thr_bypass", {31'd0, bypass}, 0);
    step(1'b1);

    // Held through k+LC: long press
    repeat (LC + 1) step(1'b0);
    chk("long_pulse", {31'd0, long_pulse}, 1);
    chk("long_bypass", {31'd0, bypass}, 1);
    chk("long_mode", {30'd0, mode}, 2);
    repeat (5) step(1'b0);
    step(1'b1);
    chk("long_release", {31'd0, short_pulse}, 0);
    repeat (2) step(1'b1);

    // Short press while bypassed
    repeat (3) step(1'b0);
    step(1'b1);
    chk("byp_bypass", {31'd0, bypass}, 0);
    chk("byp_mode", {30'd0, mode}, 2);
    chk("byp_chg", {31'd0, mode_changed}, 1);
    step(1'b1);
    chk("byp_chg_end", {31'd0, mode_changed}, 0);

    // Reset mid-hold with bypass=1, mode=2
    repeat (LC + 1) step(1'b0);
    step(1'b1);
    step(1'b1);
    repeat (6) step(1'b0);
    chk("mid_bypass", {31'd0, bypass}, 1);
    chk("mid_mode", {30'd0, mode}, 2);
    async_reset(1'b0);
    repeat (10) step(1'b0);
    repeat (2) step(1'b1);

    // Held through reset
    async_reset(1'b0);
    repeat (20) step(1'b0);
    repeat (2) step(1'b1);
    repeat (3) step(1'b0);
    step(1'b1);
    chk("held_mode", {30'd0, mode}, 1);
    step(1'b1);

    // Randomised presses, glitches and occasional resets
    for (int i = 0; i < 80; i++) begin
      press($urandom_range(1, 12), $urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 9)) step(1'b0);
        async_reset($urandom_range(0, 1) == 1 ? 1'b1 : 1'b0);
      end
    end
    repeat (3) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_mode_select.md
# button_mode_select

Downstream consumer of the debounced push-button level. Turns the stable button level into classified press events: short press and long press. It maintains the effect-selection state that drives the VFX pipeline's mode multiplexer:
- a `mode` index that wraps around;
- a `bypass` flag.

All outputs are registered. The block assumes its input is already synchronised and debounced, and adds no filtering of its own.

## Interface
- `NUM_MODES`, default 4: number of effect modes. Legal range is 2 or more. `mode` cycles through 0 to NUM_MODES-1.
- `LONG_COUNTS`, default 50_000_000: number of clock cycles a press must be held to count as long. This is 1 s at 50 MHz. Legal range is 2 or more.
- `ACTIVE_LOW`, default 1: sets the input polarity. 1 means `btn_level`=0 is pressed (board KEYs).

Ports:
- `clk`, in, 1: single clock domain, 50 MHz nominal.
- `rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `btn_level`, in, 1: debounced button level, synchronous to `clk`.
- `mode`, out, $clog2(NUM_MODES): current effect index.
- `bypass`, out, 1: 1 means effects are bypassed.
- `short_pulse`, out, 1: one-cycle strobe on a classified short press.
- `long_pulse`, out, 1: one-cycle strobe on a classified long press.
- `mode_changed`, out, 1: one-cycle strobe whenever `mode` or `bypass` changes.

## Operation
- Press level: `pressed` = ACTIVE_LOW ? !btn_level : btn_level.
- Edge detection: `prev_pressed` register; a press edge is `pressed & !prev_pressed`.
- Reset value of `prev_pressed` is 1. A button held across reset therefore produces no event until it is released and pressed again.
- Hold counter `hold_cnt` is $clog2(LONG_COUNTS) bits wide and is only meaningful in PRESSED.

FSM states: IDLE, PRESSED, LONG.
- **IDLE**
  - Press edge: go to PRESSED, set `hold_cnt` to 0.
  - Otherwise: stay in IDLE.
- **PRESSED**, evaluated in priority order:
  1. `!pressed`: go to IDLE. Assert `short_pulse`. Apply the short action.
  2. `pressed` and `hold_cnt` == LONG_COUNTS-1: go to LONG. Assert `long_pulse`. Toggle `bypass`. Assert `mode_changed`.
  3. Otherwise: increment `hold_cnt`.
- **LONG**
  - `!pressed`: go to IDLE. No pulse.
  - Otherwise: stay in LONG. The counter is frozen.

Short action:
- If `bypass`=1: clear `bypass`. `mode` is unchanged.
- If `bypass`=0: `mode` becomes 0 when `mode` == NUM_MODES-1, otherwise `mode`+1.
- Both cases assert `mode_changed`.

Further rules:
- `hold_cnt` never wraps, because PRESSED is always exited at LONG_COUNTS-1.
- Mode arithmetic is unsigned with an explicit wrap compare; there is no reliance on power-of-two overflow.
- All strobes are high for exactly one cycle. Strobes never overlap each other except the required pairing with `mode_changed`.

Reset behaviour:
- Reset values: state IDLE, `hold_cnt` 0, `mode` 0, `bypass` 0, all strobes 0, `prev_pressed` 1.
- Asserting `rst_n` mid-operation (in any state) forces these values immediately, without waiting for a clock edge.
- Deassertion takes effect at the next `clk` edge.

## Timing
- Press sampled at edge k: the state is PRESSED after edge k.
- Release sampled at edge m, where m−k < LONG_COUNTS:
  - `short_pulse`, `mode_changed` and the new `mode`/`bypass` are all visible after edge m.
  - The strobes deassert after edge m+1.
- Long classification:
  - `pressed` must be sampled high at every edge k..k+LONG_COUNTS.
  - `long_pulse`, `mode_changed` and the toggled `bypass` are then visible after edge k+LONG_COUNTS.
- Release sampled exactly at edge k+LONG_COUNTS: short press. Condition 1 has priority.
- Latency from a sampled input change to the output is 1 cycle. There is no combinational path from input to output.
- Back-to-back presses: a new press edge in IDLE is accepted as early as the cycle after returning to IDLE.

## Test plan
All scenarios use NUM_MODES=3, LONG_COUNTS=8, ACTIVE_LOW=1.

1. Reset:
   - Stimulus: hold `rst_n` low, then release it with `btn_level`=1.
   - Response: `mode`=0, `bypass`=0, all strobes 0, no events.
2. Short-press wrap:
   - Stimulus: four presses, each 3 cycles long, separated by gaps.
   - Response: `mode` steps 1, 2, 0, 1. Each press gives a 1-cycle `short_pulse` plus `mode_changed`, appearing 1 cycle after release.
3. Long threshold:
   - Stimulus A: press sampled at edge k, held through edge k+8.
   - Response A: `long_pulse` and `bypass`=1 after edge k+8, `mode` unchanged, no strobe on release.
   - Stimulus B: release sampled at edge k+8.
   - Response B: `short_pulse`, `mode`+1, `bypass` unchanged.
4. Short press in bypass:
   - Stimulus: from `bypass`=1, `mode`=2, a 3-cycle press.
   - Response: `bypass`=0, `mode` stays 2, `short_pulse` and `mode_changed` for 1 cycle.
5. Held through reset:
   - Stimulus: `btn_level`=0 while `rst_n` deasserts, held 20 cycles, released, then pressed for 3 cycles.
   - Response: no strobes until the second press, which gives `mode`=1.
6. Reset mid-hold:
   - Stimulus: assert `rst_n` low asynchronously at `hold_cnt`=5 with `bypass`=1, `mode`=2.
   - Response: outputs clear with no clock edge. After reset, with the button still held, there are no events.
